// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// State/mode encodings and the dwell-counter width helper.
package decoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of a counter spanning 0..dwell-1, never narrower than 1 bit.
    function automatic int dwell_w(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_onehot_decoder_if.sv
// Control/status bundle between a host and seq_onehot_decoder.
// The host drives the master side; the decoder is the slave.
interface seq_onehot_decoder_if #(
    parameter int N = 3
);
    logic              en;
    logic              mode;
    logic [N-1:0]      sel;
    logic              sel_valid;
    logic              scan_start;
    logic              scan_stop;
    logic [(1<<N)-1:0] dout;
    logic [N-1:0]      index;
    logic              busy;
    logic              done;

    modport master (
        output en, mode, sel, sel_valid, scan_start, scan_stop,
        input  dout, index, busy, done
    );

    modport slave (
        input  en, mode, sel, sel_valid, scan_start, scan_stop,
        output dout, index, busy, done
    );
endinterface

// File: rtl/seq_onehot_decoder_onehot_dec.sv
// Combinational binary to one-hot decoder, N in, 2^N out.
// Reusable by any block needing a select-to-strobe expansion.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]      bin_i,
    output logic [(1<<N)-1:0] oh_o
);
    localparam int M = 1 << N;

    assign oh_o = M'(1) << bin_i;
endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot decoder with DIRECT load and timed SCAN walk.
// Output is forced low while disabled and restored on re-enable.
module seq_onehot_decoder
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 1,
    parameter int WRAP  = 0
) (
    input logic                 clk,
    input logic                 rst,
    seq_onehot_decoder_if.slave bus
);
    localparam int M  = 1 << N;
    localparam int DW = dwell_w(DWELL);
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [N-1:0]    index_q, index_d;
    logic [M-1:0]    dout_q, dout_d, dec_oh;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            held_q, held_d;
    logic            on_d;

    onehot_dec #(.N(N)) u_dec (
        .bin_i (index_d),
        .oh_o  (dec_oh)
    );

    assign dout_d = on_d ? dec_oh : '0;

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        index_d = index_q;
        busy_d  = busy_q;
        held_d  = held_q;
        done_d  = 1'b0;
        on_d    = 1'b0;
        if (state_q == ST_SCAN && bus.scan_stop) begin
            state_d = ST_IDLE;
            dwell_d = '0;
            index_d = '0;
            busy_d  = 1'b0;
            held_d  = 1'b0;
        end else if (bus.en) begin
            unique case (state_q)
                ST_IDLE: begin
                    // held_q restores a DIRECT load after an enable gap
                    on_d = held_q;
                    if (bus.mode == MODE_SCAN && bus.scan_start) begin
                        state_d = ST_SCAN;
                        index_d = '0;
                        dwell_d = '0;
                        busy_d  = 1'b1;
                        held_d  = 1'b0;
                        on_d    = 1'b1;
                    end else if (bus.mode == MODE_DIRECT && bus.sel_valid) begin
                        index_d = bus.sel;
                        held_d  = 1'b1;
                        on_d    = 1'b1;
                    end
                end
                ST_SCAN: begin
                    on_d = 1'b1;
                    if (dwell_q == DW_LAST) begin
                        dwell_d = '0;
                        index_d = index_q + N'(1);
                        if (index_q == '1) begin
                            done_d = 1'b1;
                            if (WRAP == 0) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                on_d    = 1'b0;
                            end
                        end
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            index_q <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            index_q <= index_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            held_q  <= held_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.index = index_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed bench: three decoder configurations on one clock.
// u0: DWELL=2 WRAP=0, u1: DWELL=1 WRAP=1, u2: DWELL=3 WRAP=0.
module tb_seq_onehot_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                           8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    seq_onehot_decoder_if #(.N(3)) b0 ();
    seq_onehot_decoder_if #(.N(3)) b1 ();
    seq_onehot_decoder_if #(.N(3)) b2 ();

    seq_onehot_decoder #(.N(3), .DWELL(2), .WRAP(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    seq_onehot_decoder #(.N(3), .DWELL(1), .WRAP(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1));
    seq_onehot_decoder #(.N(3), .DWELL(3), .WRAP(0)) u2 (
        .clk(clk), .rst(rst), .bus(b2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        b0.en = 1'b0; b0.mode = 1'b0; b0.sel = '0; b0.sel_valid = 1'b0;
        b0.scan_start = 1'b0; b0.scan_stop = 1'b0;
        b1.en = 1'b0; b1.mode = 1'b0; b1.sel = '0; b1.sel_valid = 1'b0;
        b1.scan_start = 1'b0; b1.scan_stop = 1'b0;
        b2.en = 1'b0; b2.mode = 1'b0; b2.sel = '0; b2.sel_valid = 1'b0;
        b2.scan_start = 1'b0; b2.scan_stop = 1'b0;

        // Reset
        step(); step();
        chk("rst_dout", 32'(b0.dout), 32'h0);
        chk("rst_index", 32'(b0.index), 32'h0);
        chk("rst_busy", 32'(b0.busy), 32'h0);
        chk("rst_done", 32'(b0.done), 32'h0);
        chk("rst_u1_dout", 32'(b1.dout), 32'h0);
        chk("rst_u2_busy", 32'(b2.busy), 32'h0);
        rst = 1'b0;
        b0.en = 1'b1; b1.en = 1'b1; b2.en = 1'b1;

        // DIRECT load and hold
        b0.sel = 3'd5; b0.sel_valid = 1'b1;
        step();
        chk("dir5_dout", 32'(b0.dout), 32'h20);
        chk("dir5_index", 32'(b0.index), 32'd5);
        b0.sel_valid = 1'b0; b0.sel = 3'd1;
        step();
        chk("dir5_hold", 32'(b0.dout), 32'h20);
        for (int i = 0; i < 8; i++) begin
            b0.sel = 3'(i); b0.sel_valid = 1'b1;
            step();
            chk("sweep_dout", 32'(b0.dout), 32'(oh[i]));
            chk("sweep_index", 32'(b0.index), 32'(i));
        end
        b0.sel_valid = 1'b0;

        // SCAN single pass, DWELL=2; stray sel_valid / scan_start ignored
        b0.mode = 1'b1; b0.scan_start = 1'b1;
        step();
        chk("scan_e0_dout", 32'(b0.dout), 32'h01);
        chk("scan_e0_busy", 32'(b0.busy), 32'h1);
        b0.scan_start = 1'b0;
        for (int e = 1; e < 16; e++) begin
            if (e == 4) begin b0.sel = 3'd7; b0.sel_valid = 1'b1; end
            if (e == 6) begin b0.sel_valid = 1'b0; b0.scan_start = 1'b1; end
            if (e == 7) b0.scan_start = 1'b0;
            step();
            chk("scan_dout", 32'(b0.dout), 32'(oh[e/2]));
            chk("scan_busy", 32'(b0.busy), 32'h1);
            chk("scan_done", 32'(b0.done), 32'h0);
        end
        step();
        chk("end_dout", 32'(b0.dout), 32'h0);
        chk("end_busy", 32'(b0.busy), 32'h0);
        chk("end_done", 32'(b0.done), 32'h1);
        chk("end_index", 32'(b0.index), 32'h0);
        step();
        chk("end_done_pulse", 32'(b0.done), 32'h0);

        // scan_start with mode=0 starts nothing
        b0.mode = 1'b0; b0.scan_start = 1'b1;
        step();
        chk("nomode_busy", 32'(b0.busy), 32'h0);
        chk("nomode_dout", 32'(b0.dout), 32'h0);
        b0.scan_start = 1'b0;

        // Abort at index 3
        b0.mode = 1'b1; b0.scan_start = 1'b1;
        step();
        b0.scan_start = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        chk("abort_pre_index", 32'(b0.index), 32'd3);
        b0.scan_stop = 1'b1;
        step();
        chk("abort_dout", 32'(b0.dout), 32'h0);
        chk("abort_busy", 32'(b0.busy), 32'h0);
        chk("abort_done", 32'(b0.done), 32'h0);
        b0.scan_stop = 1'b0;
        step();
        chk("abort_done2", 32'(b0.done), 32'h0);

        // Abort coincident with the final step
        b0.scan_start = 1'b1;
        step();
        b0.scan_start = 1'b0;
        for (int e = 1; e <= 15; e++) step();
        chk("lastab_pre", 32'(b0.dout), 32'h80);
        b0.scan_stop = 1'b1;
        step();
        chk("lastab_done", 32'(b0.done), 32'h0);
        chk("lastab_busy", 32'(b0.busy), 32'h0);
        chk("lastab_dout", 32'(b0.dout), 32'h0);
        b0.scan_stop = 1'b0;

        // WRAP=1, DWELL=1
        b1.mode = 1'b1; b1.scan_start = 1'b1;
        step();
        chk("wrap_e0", 32'(b1.dout), 32'h01);
        b1.scan_start = 1'b0;
        for (int e = 1; e < 20; e++) begin
            step();
            chk("wrap_dout", 32'(b1.dout), 32'(oh[e % 8]));
            chk("wrap_busy", 32'(b1.busy), 32'h1);
            chk("wrap_done", 32'(b1.done), 32'((e == 8) || (e == 16)));
        end
        b1.scan_stop = 1'b1;
        step();
        chk("wrap_stop_busy", 32'(b1.busy), 32'h0);
        b1.scan_stop = 1'b0;

        // Enable freeze, DWELL=3, index 2 with one dwell cycle used
        b2.mode = 1'b1; b2.scan_start = 1'b1;
        step();
        b2.scan_start = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        chk("frz_pre", 32'(b2.dout), 32'h04);
        b2.en = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            chk("frz_dout", 32'(b2.dout), 32'h0);
            chk("frz_index", 32'(b2.index), 32'd2);
            chk("frz_busy", 32'(b2.busy), 32'h1);
        end
        b2.en = 1'b1;
        step();
        chk("res1_dout", 32'(b2.dout), 32'h04);
        step();
        chk("res2_dout", 32'(b2.dout), 32'h04);
        step();
        chk("res3_dout", 32'(b2.dout), 32'h08);
        chk("res3_index", 32'(b2.index), 32'd3);

        // Reset mid-scan, then immediate DIRECT load
        b0.mode = 1'b1; b0.scan_start = 1'b1;
        step();
        b0.scan_start = 1'b0;
        step(); step(); step();
        chk("rmid_pre_busy", 32'(b0.busy), 32'h1);
        rst = 1'b1;
        step();
        chk("rmid_dout", 32'(b0.dout), 32'h0);
        chk("rmid_index", 32'(b0.index), 32'h0);
        chk("rmid_busy", 32'(b0.busy), 32'h0);
        chk("rmid_done", 32'(b0.done), 32'h0);
        chk("rmid_u2_busy", 32'(b2.busy), 32'h0);
        rst = 1'b0;
        b0.mode = 1'b0; b0.sel = 3'd6; b0.sel_valid = 1'b1;
        step();
        chk("post_rst_dout", 32'(b0.dout), 32'h40);
        chk("post_rst_index", 32'(b0.index), 32'd6);
        b0.sel_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
